// File: rtl/janus_cube_tile_sched.sv
// janus_cube_tile_sched: latches a MATMUL (M,K,N), issues one PE uop per (m,n,k) tile,
// waits for L0A/L0B entries, drains the PE pipeline and reports done with a cycle count.
module janus_cube_tile_sched #(
    parameter int ARRAY_SIZE = 16,
    parameter int DIM_W      = 16,
    parameter int L0_ENTRIES = 64,
    parameter int PIPE_LAT   = 3,
    parameter int CNT_W      = 32,
    localparam int IDX_W     = $clog2(L0_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [DIM_W-1:0]      inst_m,
    input  logic [DIM_W-1:0]      inst_k,
    input  logic [DIM_W-1:0]      inst_n,
    input  logic                  start,
    input  logic [L0_ENTRIES-1:0] l0a_valid,
    input  logic [L0_ENTRIES-1:0] l0b_valid,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic [IDX_W-1:0]      uop_a_idx,
    output logic [IDX_W-1:0]      uop_b_idx,
    output logic [DIM_W-1:0]      uop_mi,
    output logic [DIM_W-1:0]      uop_ni,
    output logic                  uop_first_k,
    output logic                  uop_last_k,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      perf_cycles
);
    localparam int LOG2_AS = $clog2(ARRAY_SIZE);
    localparam int TW      = DIM_W + 1;
    localparam int PW      = 2 * TW;
    localparam int DCW     = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOADED, ISSUE, DRAIN, DONE} state_t;

    state_t           state, state_d;
    logic [TW-1:0]    m_tiles, k_tiles, n_tiles;
    logic [TW-1:0]    tm_in, tk_in, tn_in;
    logic [DIM_W-1:0] mi, ni, ki;
    logic [DCW-1:0]   dcnt;
    logic [PW-1:0]    mk, kn;
    logic             inst_acc, go, bad, hs, lk, ln, lm, drained;

    // Tile counts are widened by one bit so a near-max dimension cannot wrap to zero.
    assign tm_in = ({1'b0, inst_m} + TW'(ARRAY_SIZE - 1)) >> LOG2_AS;
    assign tk_in = ({1'b0, inst_k} + TW'(ARRAY_SIZE - 1)) >> LOG2_AS;
    assign tn_in = ({1'b0, inst_n} + TW'(ARRAY_SIZE - 1)) >> LOG2_AS;

    assign mk  = PW'(m_tiles) * PW'(k_tiles);
    assign kn  = PW'(k_tiles) * PW'(n_tiles);
    assign bad = (m_tiles == '0) | (k_tiles == '0) | (n_tiles == '0) |
                 (mk > PW'(L0_ENTRIES)) | (kn > PW'(L0_ENTRIES));

    assign inst_ready = (state == IDLE) | (state == LOADED) | (state == DONE);
    assign busy       = (state == ISSUE) | (state == DRAIN);
    assign done       = state == DONE;
    assign inst_acc   = inst_valid & inst_ready;
    assign go         = (state == LOADED) & start & ~inst_acc;

    assign lk      = TW'(ki) == k_tiles - TW'(1);
    assign ln      = TW'(ni) == n_tiles - TW'(1);
    assign lm      = TW'(mi) == m_tiles - TW'(1);
    assign drained = dcnt == DCW'(PIPE_LAT - 1);

    // L0 indices only need the low IDX_W bits, so the product is formed modulo 2^IDX_W.
    assign uop_a_idx   = IDX_W'(mi) * IDX_W'(k_tiles) + IDX_W'(ki);
    assign uop_b_idx   = IDX_W'(ki) * IDX_W'(n_tiles) + IDX_W'(ni);
    assign uop_mi      = mi;
    assign uop_ni      = ni;
    assign uop_first_k = (state == ISSUE) & (ki == '0);
    assign uop_last_k  = (state == ISSUE) & lk;
    assign uop_valid   = (state == ISSUE) & l0a_valid[uop_a_idx] & l0b_valid[uop_b_idx];
    assign hs          = uop_valid & uop_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = inst_acc ? LOADED : IDLE;
            LOADED:  state_d = inst_acc ? LOADED : start ? (bad ? DONE : ISSUE) : LOADED;
            ISSUE:   state_d = (hs & lk & ln & lm) ? DRAIN : ISSUE;
            DRAIN:   state_d = drained ? DONE : DRAIN;
            DONE:    state_d = inst_acc ? LOADED : DONE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_tiles     <= '0;
            k_tiles     <= '0;
            n_tiles     <= '0;
            mi          <= '0;
            ni          <= '0;
            ki          <= '0;
            dcnt        <= '0;
            err         <= 1'b0;
            perf_cycles <= '0;
        end else if (clear) begin
            state       <= IDLE;
            m_tiles     <= '0;
            k_tiles     <= '0;
            n_tiles     <= '0;
            mi          <= '0;
            ni          <= '0;
            ki          <= '0;
            dcnt        <= '0;
            err         <= 1'b0;
            perf_cycles <= '0;
        end else begin
            state <= state_d;
            if (inst_acc) begin
                m_tiles <= tm_in;
                k_tiles <= tk_in;
                n_tiles <= tn_in;
                err     <= 1'b0;
            end
            if (go) begin
                err <= bad;
                if (!bad) begin
                    mi          <= '0;
                    ni          <= '0;
                    ki          <= '0;
                    perf_cycles <= '0;
                end
            end else if (busy) perf_cycles <= perf_cycles + CNT_W'(1);
            if (hs) begin
                ki <= lk ? '0 : ki + DIM_W'(1);
                ni <= lk ? (ln ? '0 : ni + DIM_W'(1)) : ni;
                mi <= (lk & ln) ? (lm ? '0 : mi + DIM_W'(1)) : mi;
            end
            dcnt <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
        end
    end
endmodule

// File: tb/tb_janus_cube_tile_sched.sv
// tb_janus_cube_tile_sched: table-driven instructions with a uop scoreboard, plus
// hand-written stall, back-pressure, reset and clear sequences.
module tb_janus_cube_tile_sched;
    localparam int DW = 16, L0 = 64, IW = 6, CW = 32;

    logic          clk = 0, rst_n = 0, clear = 0, inst_valid = 0, start = 0, uop_ready = 1;
    logic [DW-1:0] inst_m = 0, inst_k = 0, inst_n = 0;
    logic [L0-1:0] l0a_valid = '1, l0b_valid = '1;

    logic          inst_ready, uop_valid, uop_first_k, uop_last_k, busy, done, err;
    logic [IW-1:0] uop_a_idx, uop_b_idx;
    logic [DW-1:0] uop_mi, uop_ni;
    logic [CW-1:0] perf_cycles;

    logic          inst_ready2, uop_valid2, uop_first_k2, uop_last_k2, busy2, done2, err2;
    logic [IW-1:0] uop_a_idx2, uop_b_idx2;
    logic [DW-1:0] uop_mi2, uop_ni2;
    logic [CW-1:0] perf_cycles2;

    janus_cube_tile_sched dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_m(inst_m), .inst_k(inst_k), .inst_n(inst_n), .start(start),
        .l0a_valid(l0a_valid), .l0b_valid(l0b_valid), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_a_idx(uop_a_idx), .uop_b_idx(uop_b_idx), .uop_mi(uop_mi), .uop_ni(uop_ni),
        .uop_first_k(uop_first_k), .uop_last_k(uop_last_k), .busy(busy), .done(done), .err(err),
        .perf_cycles(perf_cycles)
    );

    janus_cube_tile_sched #(.ARRAY_SIZE(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inst_valid(inst_valid), .inst_ready(inst_ready2),
        .inst_m(inst_m), .inst_k(inst_k), .inst_n(inst_n), .start(start),
        .l0a_valid(l0a_valid), .l0b_valid(l0b_valid), .uop_valid(uop_valid2), .uop_ready(uop_ready),
        .uop_a_idx(uop_a_idx2), .uop_b_idx(uop_b_idx2), .uop_mi(uop_mi2), .uop_ni(uop_ni2),
        .uop_first_k(uop_first_k2), .uop_last_k(uop_last_k2), .busy(busy2), .done(done2), .err(err2),
        .perf_cycles(perf_cycles2)
    );

    always #5 clk = ~clk;

    typedef struct {int mi, ni, ki, a, b, fk, lk;} uop_t;
    typedef struct {int m, k, n; bit e; int uops; longint perf;} vec_t;

    uop_t q[$], q2[$];
    int   checks = 0, errors = 0, acc = 0, acc2 = 0;
    bit   mon2 = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(int as, int m, int k, int n, bit second);
        int mt, kt, nt;
        uop_t u;
        mt = (m + as - 1) / as;
        kt = (k + as - 1) / as;
        nt = (n + as - 1) / as;
        for (int a = 0; a < mt; a++)
            for (int b = 0; b < nt; b++)
                for (int c = 0; c < kt; c++) begin
                    u = '{a, b, c, (a * kt + c) % L0, (c * nt + b) % L0, c == 0, c == kt - 1};
                    if (second) q2.push_back(u);
                    else q.push_back(u);
                end
    endtask

    always @(negedge clk) begin
        uop_t e;
        if (rst_n && uop_valid && uop_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uop_unexpected: got uop mi=%0d ni=%0d a=%0d required none", uop_mi, uop_ni, uop_a_idx);
            end else begin
                e = q.pop_front();
                chk("uop_mi", uop_mi, e.mi);
                chk("uop_ni", uop_ni, e.ni);
                chk("uop_a_idx", uop_a_idx, e.a);
                chk("uop_b_idx", uop_b_idx, e.b);
                chk("uop_first_k", uop_first_k, e.fk);
                chk("uop_last_k", uop_last_k, e.lk);
            end
            acc++;
        end
    end

    always @(negedge clk) begin
        uop_t e;
        if (mon2 && rst_n && uop_valid2 && uop_ready) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uop32_unexpected: got uop mi=%0d required none", uop_mi2);
            end else begin
                e = q2.pop_front();
                chk("uop32_a_idx", uop_a_idx2, e.a);
                chk("uop32_b_idx", uop_b_idx2, e.b);
                chk("uop32_mi", uop_mi2, e.mi);
                chk("uop32_ni", uop_ni2, e.ni);
            end
            if (acc2 == 3) begin
                chk("uop32_4th_mi", uop_mi2, 0);
                chk("uop32_4th_ni", uop_ni2, 1);
                chk("uop32_4th_first_k", uop_first_k2, 0);
                chk("uop32_4th_last_k", uop_last_k2, 1);
                chk("uop32_4th_a", uop_a_idx2, 1);
                chk("uop32_4th_b", uop_b_idx2, 3);
            end
            acc2++;
        end
    end

    task automatic load(int m, int k, int n);
        inst_m = DW'(m);
        inst_k = DW'(k);
        inst_n = DW'(n);
        inst_valid = 1;
        @(posedge clk);
        #1 inst_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(int budget, bit tog);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (tog) uop_ready = ~uop_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles required done=1", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        logic [IW-1:0] sa, sb;
        logic [DW-1:0] smi, sni;
        bit hit;
        tbl[0] = '{64, 64, 64, 0, 64, 67};
        tbl[1] = '{16, 16, 16, 0, 1, 4};
        tbl[2] = '{17, 33, 1, 0, 6, 9};
        tbl[3] = '{0, 64, 64, 1, 0, -1};
        tbl[4] = '{128, 64, 128, 0, 256, 259};
        tbl[5] = '{256, 256, 256, 1, 0, -1};
        tbl[6] = '{128, 128, 128, 0, 512, 515};
        tbl[7] = '{129, 128, 16, 1, 0, -1};
        tbl[8] = '{65535, 16, 16, 1, 0, -1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_perf", perf_cycles, 0);
        chk("rst_a_idx", uop_a_idx, 0);
        chk("rst_first_k", uop_first_k, 0);
        rst_n = 1;
        do_start();
        chk("start_idle_busy", busy, 0);
        chk("start_idle_done", done, 0);

        for (int i = 0; i < 9; i++) begin
            load(tbl[i].m, tbl[i].k, tbl[i].n);
            chk("load_done", done, 0);
            chk("load_err", err, 0);
            chk("load_ready", inst_ready, 1);
            acc = 0;
            if (!tbl[i].e) push_exp(16, tbl[i].m, tbl[i].k, tbl[i].n, 0);
            if (i == 0) begin
                mon2 = 1;
                acc2 = 0;
                push_exp(32, 64, 64, 64, 1);
            end
            do_start();
            wait_done(2000, 0);
            chk("vec_err", err, tbl[i].e);
            chk("vec_done", done, 1);
            chk("vec_uops", acc, tbl[i].uops);
            chk("vec_queue_left", q.size(), 0);
            chk("vec_busy", busy, 0);
            if (!tbl[i].e) chk("vec_perf", perf_cycles, tbl[i].perf);
            if (i == 0) begin
                chk("as32_done", done2, 1);
                chk("as32_perf", perf_cycles2, 11);
                chk("as32_uops", acc2, 8);
                chk("as32_queue_left", q2.size(), 0);
                mon2 = 0;
            end
        end

        // L0B entry 5 arrives late: the issue must stall on it without reordering.
        load(64, 64, 64);
        push_exp(16, 64, 64, 64, 0);
        l0b_valid[5] = 0;
        acc = 0;
        do_start();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = busy && !uop_valid && uop_b_idx == 5;
        end
        chk("stall_reached", hit, 1);
        sa = uop_a_idx;
        sb = uop_b_idx;
        smi = uop_mi;
        sni = uop_ni;
        chk("stall_a", sa, 1);
        chk("stall_ni", sni, 1);
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", uop_valid, 0);
            chk("stall_a_stable", uop_a_idx, sa);
            chk("stall_b_stable", uop_b_idx, sb);
            chk("stall_mi_stable", uop_mi, smi);
            if (i < 19) @(negedge clk);
        end
        @(posedge clk);
        #1 l0b_valid[5] = 1;
        wait_done(500, 0);
        chk("stall_perf", perf_cycles, 87);
        chk("stall_uops", acc, 64);
        chk("stall_queue_left", q.size(), 0);

        // Alternating back-pressure, ready low in the first issue cycle.
        load(64, 64, 64);
        push_exp(16, 64, 64, 64, 0);
        acc = 0;
        uop_ready = 1;
        do_start();
        uop_ready = 0;
        wait_done(500, 1);
        uop_ready = 1;
        chk("toggle_perf", perf_cycles, 131);
        chk("toggle_uops", acc, 64);
        chk("toggle_queue_left", q.size(), 0);

        // Async reset mid-issue.
        load(64, 64, 64);
        push_exp(16, 64, 64, 64, 0);
        acc = 0;
        do_start();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 0;
        #1;
        chk("arst_inst_ready", inst_ready, 1);
        chk("arst_uop_valid", uop_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_perf", perf_cycles, 0);
        chk("arst_mi", uop_mi, 0);
        chk("arst_uops_before", acc, 10);
        @(posedge clk);
        #1 rst_n = 1;
        q.delete();
        do_start();
        chk("arst_start_ignored", busy, 0);

        // Soft clear mid-drain.
        load(64, 64, 64);
        push_exp(16, 64, 64, 64, 0);
        acc = 0;
        do_start();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = busy && !uop_valid && acc == 64;
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        chk("drain_reached", hit, 1);
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        chk("clr_inst_ready", inst_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_uop_valid", uop_valid, 0);
        chk("clr_perf", perf_cycles, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("clr_no_done", done, 0);
        chk("clr_queue_left", q.size(), 0);
        do_start();
        chk("clr_start_ignored", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
